dm_mem_stage: RTL and testbench
===============================

Name: dm_mem_stage

Overview:
- Data-memory stage of the P6 pipelined MIPS CPU. Performs word, halfword and byte stores with byte enables and a synchronous word read.
- Registers the read word together with the address and load opcode, so the downstream load data extender sees them aligned in the next (WB) cycle.
- After reset, clears the whole memory using a sweep state machine.
- Flags misaligned or out-of-range accesses.

Parameters:
DEPTH, 3072, number of 32-bit words (byte range 0 .. 4*DEPTH-1)
AW, 12, word-index width, at least clog2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
Stall  input  1  1 = hold all registered outputs; suppress the write
MemWrite  input  1  store request this cycle
MemRead  input  1  load request this cycle
SOp  input  2  store size: 0 sw, 1 sh, 2 sb, 3 reserved (treated as no store)
LdOp  input  3  load opcode passed to the extender: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh
Addr  input  32  byte address from ALU
WD  input  32  store data (rt value after forwarding)
RD  output  32  registered raw word read (extender Din)
AddrQ  output  32  registered Addr (extender Addr)
LdOpQ  output  3  registered LdOp (extender Op)
AdEL  output  1  registered load address error
AdES  output  1  registered store address error
Busy  output  1  high while the clear sweep runs; the pipeline stalls on it

Behaviour:
- Reset (reset==0 at posedge):
  - state<=INIT, clr_ptr<=0.
  - RD, AddrQ, LdOpQ, AdEL, AdES <= 0.
  - Reset has priority over everything else, including a sweep already in progress (the sweep restarts at 0).
- INIT state:
  - Each cycle writes 0 to mem[clr_ptr], then clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, the next state is RUN.
  - Busy = (state==INIT), combinational. Busy is therefore high for exactly DEPTH cycles after reset releases.
  - All request inputs are ignored. RD/AddrQ/LdOpQ/AdEL/AdES hold 0.
- RUN state, word index idx = Addr[AW+1:2]; in_range = (Addr < 4*DEPTH).
- Store enable and byte enables BE[3:0]:
  - sw: BE=1111, requires Addr[1:0]==0.
  - sh: BE = Addr[1] ? 1100 : 0011, requires Addr[0]==0.
  - sb: BE = 0001 << Addr[1:0].
- Write lane data:
  - sw: WD.
  - sh: {WD[15:0], WD[15:0]}.
  - sb: {4{WD[7:0]}}.
- Write condition: MemWrite & !Stall & aligned & in_range & SOp!=3. Only the bytes selected by BE are updated at the posedge.
- Store error: if MemWrite & !Stall & (!aligned | !in_range), then AdES<=1 for one cycle and no byte is written. Otherwise AdES<=0 when !Stall.
- Load alignment:
  - LdOp 0 requires Addr[1:0]==0.
  - LdOp 3/4 require Addr[0]==0.
  - LdOp 1/2 are always aligned.
- Load error: AdEL<=MemRead & (!aligned | !in_range) when !Stall.
- Read path, when !Stall, at each posedge:
  - RD <= in_range ? word : 0, with write-first semantics: a same-cycle write to idx makes RD the merged post-write word.
  - AddrQ<=Addr, LdOpQ<=LdOp.
  - RD updates whether or not MemRead is set.
- Stall==1: RD, AddrQ, LdOpQ, AdEL and AdES hold; no write.
- Simultaneous MemWrite & MemRead is legal; the write-first rule applies.
- Latency: store visible to any read issued in the same or a later cycle; load data on RD one cycle after request.

Decomposition:
- Shared package holds:
  - SOp encodings (SW=0, SH=1, SB=2).
  - LdOp encodings (LW=0, LBU=1, LB=2, LHU=3, LH=4), shared with the extender.
  - Default DEPTH.
- One natural sub-module, dm_be_gen: combinational, SOp+Addr[1:0]+WD -> BE, lane data, aligned.
- The RAM array, the sweep FSM and the output registers stay in dm_mem_stage.

Test Plan:
- Reset sweep: hold reset=0 for 2 cycles, release -> Busy high exactly 3072 cycles, then 0; lw from 0x0000 and from 0x2FFC returns RD=0x00000000.
- Stores then load: sw 0x11223344 @0x10; sb 0xAA @0x11; sh 0xBEEF @0x12; lw @0x10 next cycle -> RD=0xBEEFAA44, AddrQ=0x10, LdOpQ=0.
- Write-first: sw 0xCAFEBABE @0x20 with MemRead and LdOp=0 in the same cycle -> next cycle RD=0xCAFEBABE.
- Misalignment and range:
  - sh @0x13 -> AdES=1 for one cycle, memory unchanged.
  - lw @0x22 -> AdEL=1.
  - lb @0x23 -> AdEL=0.
  - sw @0x3000 -> AdES=1; lw @0x3000 -> RD=0, AdEL=1.
- Stall: load @0x10 captured, then Stall=1 for 3 cycles with changing Addr and MemWrite=1 -> RD/AddrQ/LdOpQ unchanged, memory unchanged.
- Reset mid-sweep: assert reset at sweep cycle 100 after a prior word was written -> sweep restarts, Busy lasts a further 3072 cycles, the written word reads 0 afterwards.

Source files
------------

// File: rtl/dm_mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// dm_mem_stage_pkg
// Shared definitions for the data-memory stage and the load data extender:
//   - store size encodings (SOp)
//   - load opcode encodings (LdOp), the same values the extender decodes
//   - default memory geometry
//   - helper that decides whether a load opcode is aligned for an address
// -----------------------------------------------------------------------------
package dm_mem_stage_pkg;

  // Default geometry: 3072 words = 12 KiB, word index fits in 12 bits.
  localparam int DM_DEPTH = 3072;
  localparam int DM_AW    = 12;

  typedef enum logic [1:0] {
    SOP_SW  = 2'd0,
    SOP_SH  = 2'd1,
    SOP_SB  = 2'd2,
    SOP_RSV = 2'd3
  } sop_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LBU = 3'd1,
    LD_LB  = 3'd2,
    LD_LHU = 3'd3,
    LD_LH  = 3'd4
  } ld_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dm_state_e;

  // Word loads need a word boundary, halfword loads an even address,
  // byte loads (and unused opcodes) are always aligned.
  function automatic logic ld_aligned(input logic [2:0] ld_op,
                                      input logic [1:0] addr_lo);
    logic ok;
    case (ld_op)
      LD_LW:         ok = (addr_lo == 2'b00);
      LD_LHU, LD_LH: ok = (addr_lo[0] == 1'b0);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_mem_stage_be_gen.sv
// -----------------------------------------------------------------------------
// dm_be_gen
// Combinational store-lane generator. From the store size and the low address
// bits it produces the byte enables, the store data replicated onto the byte
// lanes, and whether the store is naturally aligned.
// Ports:
//   sop       in  2   store size (sw / sh / sb / reserved)
//   addr_lo   in  2   Addr[1:0]
//   wd        in  32  store data
//   be        out 4   byte enables (bit n = byte lane n)
//   lane_data out 32  store data positioned on every lane it may hit
//   aligned   out 1   store address satisfies the size alignment
//   valid     out 1   sop encodes a real store (reserved encoding = no store)
// -----------------------------------------------------------------------------
module dm_be_gen
  import dm_mem_stage_pkg::*;
(
  input  logic [1:0]  sop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        aligned,
  output logic        valid
);

  // Decode store size into enables and replicated lane data.
  always_comb begin
    be        = 4'b0000;
    lane_data = 32'h0000_0000;
    aligned   = 1'b1;
    valid     = 1'b0;
    case (sop)
      SOP_SW: begin
        be        = 4'b1111;
        lane_data = wd;
        aligned   = (addr_lo == 2'b00);
        valid     = 1'b1;
      end
      SOP_SH: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {wd[15:0], wd[15:0]};
        aligned   = (addr_lo[0] == 1'b0);
        valid     = 1'b1;
      end
      SOP_SB: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wd[7:0]}};
        aligned   = 1'b1;
        valid     = 1'b1;
      end
      default: begin
        // Reserved size: no enables, nothing is stored and no error raised.
        be        = 4'b0000;
        lane_data = 32'h0000_0000;
        aligned   = 1'b1;
        valid     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_mem_stage.sv
// -----------------------------------------------------------------------------
// dm_mem_stage
// Data-memory stage of the pipelined MIPS CPU. Byte-enabled stores, a word
// read registered together with the address and load opcode for the WB-stage
// extender, a post-reset clear sweep, and address-error flags.
// Ports:
//   clk      in  1   rising-edge clock
//   reset    in  1   synchronous active-low reset
//   Stall    in  1   hold registered outputs, suppress the write
//   MemWrite in  1   store request
//   MemRead  in  1   load request
//   SOp      in  2   store size
//   LdOp     in  3   load opcode forwarded to the extender
//   Addr     in  32  byte address
//   WD       in  32  store data
//   RD       out 32  registered raw word (write-first)
//   AddrQ    out 32  registered Addr
//   LdOpQ    out 3   registered LdOp
//   AdEL     out 1   registered load address error
//   AdES     out 1   registered store address error
//   Busy     out 1   clear sweep in progress
// -----------------------------------------------------------------------------
module dm_mem_stage
  import dm_mem_stage_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  SOp,
  input  logic [2:0]  LdOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [31:0] AddrQ,
  output logic [2:0]  LdOpQ,
  output logic        AdEL,
  output logic        AdES,
  output logic        Busy
);

  localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_IDX    = AW'(1);

  dm_state_e     state_r;
  dm_state_e     state_nxt_s;
  logic [AW-1:0] clr_ptr_r;
  logic [AW-1:0] clr_ptr_nxt_s;

  logic [31:0]   mem_r [DEPTH];

  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic [3:0]    be_s;
  logic [31:0]   lane_s;
  logic          st_aligned_s;
  logic          st_valid_s;
  logic          store_req_s;
  logic          st_err_s;
  logic          ld_err_s;
  logic          we_s;
  logic          run_s;
  logic [31:0]   old_word_s;
  logic [31:0]   merged_s;

  dm_be_gen u_be_gen (
    .sop       (SOp),
    .addr_lo   (Addr[1:0]),
    .wd        (WD),
    .be        (be_s),
    .lane_data (lane_s),
    .aligned   (st_aligned_s),
    .valid     (st_valid_s)
  );

  assign idx_s      = Addr[AW+1:2];
  assign in_range_s = (Addr < BYTE_LIMIT);
  assign run_s      = (state_r == ST_RUN);
  assign Busy       = (state_r == ST_INIT);

  // A reserved SOp is not a store, so it can neither write nor fault.
  assign store_req_s = MemWrite & st_valid_s;
  assign st_err_s    = store_req_s & (~st_aligned_s | ~in_range_s);
  assign ld_err_s    = MemRead & (~ld_aligned(LdOp, Addr[1:0]) | ~in_range_s);
  assign we_s        = run_s & store_req_s & ~Stall & st_aligned_s & in_range_s;

  // Sweep state register; reset always restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_INIT;
      clr_ptr_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
    end
  end

  // Sweep next-state: walk every word once, then hand over to RUN.
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    case (state_r)
      ST_INIT: begin
        clr_ptr_nxt_s = clr_ptr_r + ONE_IDX;
        if (clr_ptr_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nxt_s   = ST_RUN;
        clr_ptr_nxt_s = clr_ptr_r;
      end
      default: begin
        state_nxt_s   = ST_INIT;
        clr_ptr_nxt_s = '0;
      end
    endcase
  end

  // Current word at idx; out-of-range addresses read as zero and never index
  // past the array.
  assign old_word_s = in_range_s ? mem_r[idx_s] : 32'h0000_0000;

  // Write-first merge: lanes being stored this cycle replace the old bytes so
  // RD shows the post-write word.
  always_comb begin
    merged_s = old_word_s;
    for (int b = 0; b < 4; b++) begin
      if (we_s && be_s[b]) begin
        merged_s[8*b +: 8] = lane_s[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = old_word_s[8*b +: 8];
      end
    end
  end

  // Memory array: clear sweep in INIT, byte-enabled stores in RUN.
  always_ff @(posedge clk) begin
    if (reset && (state_r == ST_INIT)) begin
      mem_r[clr_ptr_r] <= 32'h0000_0000;
    end else if (reset && we_s) begin
      if (be_s[0]) mem_r[idx_s][7:0]   <= lane_s[7:0];
      if (be_s[1]) mem_r[idx_s][15:8]  <= lane_s[15:8];
      if (be_s[2]) mem_r[idx_s][23:16] <= lane_s[23:16];
      if (be_s[3]) mem_r[idx_s][31:24] <= lane_s[31:24];
    end
  end

  // Output pipeline register toward WB; zero while sweeping, frozen on Stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RD    <= 32'h0000_0000;
      AddrQ <= 32'h0000_0000;
      LdOpQ <= 3'd0;
      AdEL  <= 1'b0;
      AdES  <= 1'b0;
    end else if (!run_s) begin
      RD    <= 32'h0000_0000;
      AddrQ <= 32'h0000_0000;
      LdOpQ <= 3'd0;
      AdEL  <= 1'b0;
      AdES  <= 1'b0;
    end else if (!Stall) begin
      RD    <= merged_s;
      AddrQ <= Addr;
      LdOpQ <= LdOp;
      AdEL  <= ld_err_s;
      AdES  <= st_err_s;
    end else begin
      RD    <= RD;
      AddrQ <= AddrQ;
      LdOpQ <= LdOpQ;
      AdEL  <= AdEL;
      AdES  <= AdES;
    end
  end

endmodule

// File: tb/tb_dm_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_dm_mem_stage
// Self-checking bench for dm_mem_stage. A byte-addressed reference memory and
// expected output registers are updated once per clock from the request
// rules; directed scenarios plus a randomized run compare the DUT to it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_mem_stage;

  localparam int DEPTH  = 3072;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  sop;
  logic [2:0]  ld_op;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] addr_q;
  logic [2:0]  ld_op_q;
  logic        adel;
  logic        ades;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state.
  logic [7:0]  mem_m [NBYTES];
  logic [31:0] exp_rd;
  logic [31:0] exp_addr_q;
  logic [2:0]  exp_ld_op_q;
  logic        exp_adel;
  logic        exp_ades;

  always #5 clk = ~clk;

  dm_mem_stage #(.DEPTH(DEPTH), .AW(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .Stall    (stall),
    .MemWrite (mem_write),
    .MemRead  (mem_read),
    .SOp      (sop),
    .LdOp     (ld_op),
    .Addr     (addr),
    .WD       (wd),
    .RD       (rd),
    .AddrQ    (addr_q),
    .LdOpQ    (ld_op_q),
    .AdEL     (adel),
    .AdES     (ades),
    .Busy     (busy)
  );

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
    exp_rd      = 32'h0;
    exp_addr_q  = 32'h0;
    exp_ld_op_q = 3'd0;
    exp_adel    = 1'b0;
    exp_ades    = 1'b0;
  endfunction

  // One clock of the reference: store (if legal), then read the whole word.
  function automatic void model_step();
    int unsigned a;
    int unsigned ssize;
    int unsigned lsize;
    int unsigned base;
    bit in_r;
    if (stall) return;
    a    = addr;
    in_r = (a < NBYTES);
    case (sop)
      2'd0:    ssize = 4;
      2'd1:    ssize = 2;
      2'd2:    ssize = 1;
      default: ssize = 0;
    endcase
    case (ld_op)
      3'd0:       lsize = 4;
      3'd3, 3'd4: lsize = 2;
      default:    lsize = 1;
    endcase
    exp_ades = 1'b0;
    if (mem_write && ssize != 0) begin
      if ((a % ssize) != 0 || !in_r) begin
        exp_ades = 1'b1;
      end else begin
        for (int unsigned k = 0; k < ssize; k++) mem_m[a + k] = wd[8*k +: 8];
      end
    end
    if (in_r) begin
      base   = a - (a % 4);
      exp_rd = {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
    end else begin
      exp_rd = 32'h0;
    end
    exp_adel    = mem_read && (((a % lsize) != 0) || !in_r);
    exp_addr_q  = addr;
    exp_ld_op_q = ld_op;
  endfunction

  // Drive one request for one clock, advance the model, stop at the negedge.
  task automatic cycle(input logic mw, input logic mr, input logic [1:0] so,
                       input logic [2:0] lo, input logic [31:0] a,
                       input logic [31:0] d, input logic st);
    mem_write = mw;
    mem_read  = mr;
    sop       = so;
    ld_op     = lo;
    addr      = a;
    wd        = d;
    stall     = st;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b0;
    stall = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; sop = 2'd0; ld_op = 3'd0;
    addr = 32'h0; wd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rd !== 32'h0)   begin n_fail++; $display("FAIL reset_rd: got %h want 00000000", rd); end
    n_cmp++; if (addr_q !== 32'h0) begin n_fail++; $display("FAIL reset_addrq: got %h want 00000000", addr_q); end
    n_cmp++; if (ld_op_q !== 3'd0 || adel !== 1'b0 || ades !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ldopq=%0d adel=%b ades=%b want 0 0 0", ld_op_q, adel, ades);
    end
    n_cmp++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    // Requests during the sweep must be ignored: try storing to word 0.
    reset = 1'b1;
    mem_write = 1'b1; mem_read = 1'b1; addr = 32'h0; wd = 32'hDEAD_BEEF;
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    n_cmp++; if (cnt != DEPTH) begin n_fail++; $display("FAIL sweep_len: got %0d cycles want %0d", cnt, DEPTH); end
    n_cmp++; if (rd !== 32'h0 || ades !== 1'b0) begin
      n_fail++; $display("FAIL sweep_outputs: got rd=%h ades=%b want 00000000 0", rd, ades);
    end
    model_clear();
  endtask

  task automatic test_lw_zero();
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h0000_0000, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_zero_lo: got %h want 00000000", rd); end
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h0000_2FFC, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'h0 || adel !== 1'b0) begin
      n_fail++; $display("FAIL lw_zero_hi: got rd=%h adel=%b want 00000000 0", rd, adel);
    end
  endtask

  task automatic test_store_load();
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 32'h10, 32'h1122_3344, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 3'd0, 32'h11, 32'h0000_00AA, 1'b0);
    cycle(1'b1, 1'b0, 2'd1, 3'd0, 32'h12, 32'h0000_BEEF, 1'b0);
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL store_load_rd: got %h want beefaa44", rd); end
    n_cmp++; if (addr_q !== 32'h10 || ld_op_q !== 3'd0) begin
      n_fail++; $display("FAIL store_load_q: got addrq=%h ldopq=%0d want 00000010 0", addr_q, ld_op_q);
    end
  endtask

  task automatic test_write_first();
    cycle(1'b1, 1'b1, 2'd0, 3'd0, 32'h20, 32'hCAFE_BABE, 1'b0);
    n_cmp++; if (rd !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL write_first: got %h want cafebabe", rd); end
    // Byte store merged into the same read.
    cycle(1'b1, 1'b1, 2'd2, 3'd1, 32'h22, 32'h0000_0077, 1'b0);
    n_cmp++; if (rd !== 32'hCA77_BABE) begin n_fail++; $display("FAIL write_first_sb: got %h want ca77babe", rd); end
  endtask

  task automatic test_errors();
    cycle(1'b1, 1'b0, 2'd1, 3'd0, 32'h13, 32'h0000_1234, 1'b0);
    n_cmp++; if (ades !== 1'b1) begin n_fail++; $display("FAIL ades_sh13: got %b want 1", ades); end
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'h0, 1'b0);
    n_cmp++; if (ades !== 1'b0) begin n_fail++; $display("FAIL ades_clear: got %b want 0", ades); end
    n_cmp++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL ades_nowrite: got %h want beefaa44", rd); end
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h22, 32'h0, 1'b0);
    n_cmp++; if (adel !== 1'b1) begin n_fail++; $display("FAIL adel_lw22: got %b want 1", adel); end
    cycle(1'b0, 1'b1, 2'd0, 3'd2, 32'h23, 32'h0, 1'b0);
    n_cmp++; if (adel !== 1'b0) begin n_fail++; $display("FAIL adel_lb23: got %b want 0", adel); end
    cycle(1'b0, 1'b1, 2'd0, 3'd4, 32'h21, 32'h0, 1'b0);
    n_cmp++; if (adel !== 1'b1) begin n_fail++; $display("FAIL adel_lh21: got %b want 1", adel); end
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 32'h3000, 32'h5A5A_5A5A, 1'b0);
    n_cmp++; if (ades !== 1'b1) begin n_fail++; $display("FAIL ades_range: got %b want 1", ades); end
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h3000, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'h0 || adel !== 1'b1) begin
      n_fail++; $display("FAIL adel_range: got rd=%h adel=%b want 00000000 1", rd, adel);
    end
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 2'd0, 3'(i + 1), 32'h10 + 32'(4 * i), 32'h5555_5555 + 32'(i), 1'b1);
      n_cmp++; if (rd !== 32'hBEEF_AA44 || addr_q !== 32'h10 || ld_op_q !== 3'd0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got rd=%h addrq=%h ldopq=%0d want beefaa44 00000010 0",
                           i, rd, addr_q, ld_op_q);
      end
    end
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL stall_nowrite: got %h want beefaa44", rd); end
  endtask

  task automatic test_random();
    int unsigned r;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'h2FF0 + 32'($urandom_range(0, 31));
      else            a = $urandom;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            3'($urandom_range(0, 4)), a, $urandom, 1'($urandom_range(0, 9) == 0));
      n_cmp++;
      if (rd !== exp_rd || addr_q !== exp_addr_q || ld_op_q !== exp_ld_op_q ||
          adel !== exp_adel || ades !== exp_ades) begin
        n_fail++;
        $display("FAIL random[%0d]: got rd=%h addrq=%h ldopq=%0d adel=%b ades=%b want %h %h %0d %b %b",
                 i, rd, addr_q, ld_op_q, adel, ades, exp_rd, exp_addr_q, exp_ld_op_q, exp_adel, exp_ades);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 32'h40, 32'h1234_5678, 1'b0);
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h40, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_pre: got %h want 12345678", rd); end
    mem_write = 1'b0; mem_read = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    repeat (100) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy100: got %b want 1", busy); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    n_cmp++; if (cnt != DEPTH) begin n_fail++; $display("FAIL mid_sweep_len: got %0d cycles want %0d", cnt, DEPTH); end
    model_clear();
    cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h40, 32'h0, 1'b0);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_cleared: got %h want 00000000", rd); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_lw_zero();
    test_store_load();
    test_write_first();
    test_errors();
    test_stall();
    test_random();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
